song_data_loader: RTL and testbench

SONG_DATA_LOADER -- requirements
Module: song_data_loader

---
 rtl/song_data_loader_pkg.sv | 24 ++
 rtl/song_data_loader.sv | 127 ++++++++++++
 tb/tb_song_data_loader.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/song_data_loader_pkg.sv
// Shared definitions for the song loader: FSM state encoding and default memory geometry.
// Imported by song_data_loader and by anything that decodes its debug state port.
package song_data_loader_pkg;

    localparam int DEFAULT_DEPTH  = 4096;
    localparam int DEFAULT_ADDR_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR_LO  = 3'd1,
        ST_HDR_HI  = 3'd2,
        ST_DATA_LO = 3'd3,
        ST_DATA_HI = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERR     = 3'd6
    } loader_state_t;

    // Receiving states are exactly the ones that may consume a byte.
    function automatic logic is_receiving(input loader_state_t s);
        return (s == ST_HDR_LO) || (s == ST_HDR_HI) ||
               (s == ST_DATA_LO) || (s == ST_DATA_HI);
    endfunction

endpackage

// File: rtl/song_data_loader.sv
// Parses a byte stream (16-bit little-endian note count, then little-endian note words)
// into note-memory writes; flags completion or an oversize header.
module song_data_loader
    import song_data_loader_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic [15:0]       note_count,
    output logic              song_loaded,
    output logic              load_error,
    output loader_state_t     o_dbg_state
);

    if (DEPTH > (1 << ADDR_W)) begin : g_depth_check
        $error("song_data_loader: DEPTH exceeds 2**ADDR_W");
    end

    // Handshake: a byte moves on a rising edge when byte_valid && byte_ready;
    // byte_ready depends only on the current state, never on byte_valid.

    loader_state_t     r_state;
    logic [15:0]       r_note_count;
    logic [7:0]        r_lo_byte;
    logic [ADDR_W:0]   r_index;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [15:0]       r_wr_data;
    logic              r_song_loaded;
    logic              r_load_error;

    logic              w_xfer;
    logic [15:0]       w_hdr_count;
    logic              w_last_word;

    assign byte_ready  = is_receiving(r_state);
    assign w_xfer      = byte_valid && byte_ready;
    assign w_hdr_count = {byte_in, r_note_count[7:0]};
    // Index is one bit wider than the address so a full DEPTH load never wraps.
    assign w_last_word = ((32'(r_index) + 32'd1) == 32'(r_note_count));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_note_count  <= '0;
            r_lo_byte     <= '0;
            r_index       <= '0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_song_loaded <= 1'b0;
            r_load_error  <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        r_state       <= ST_HDR_LO;
                        r_song_loaded <= 1'b0;
                        r_load_error  <= 1'b0;
                        r_index       <= '0;
                    end
                end
                ST_HDR_LO: begin
                    if (w_xfer) begin
                        r_note_count[7:0] <= byte_in;
                        r_state           <= ST_HDR_HI;
                    end
                end
                ST_HDR_HI: begin
                    if (w_xfer) begin
                        r_note_count[15:8] <= byte_in;
                        if (w_hdr_count == 16'd0) begin
                            r_state       <= ST_DONE;
                            r_song_loaded <= 1'b1;
                        end else if (32'(w_hdr_count) > 32'(DEPTH)) begin
                            r_state      <= ST_ERR;
                            r_load_error <= 1'b1;
                        end else begin
                            r_state <= ST_DATA_LO;
                        end
                    end
                end
                ST_DATA_LO: begin
                    if (w_xfer) begin
                        r_lo_byte <= byte_in;
                        r_state   <= ST_DATA_HI;
                    end
                end
                ST_DATA_HI: begin
                    if (w_xfer) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_index[ADDR_W-1:0];
                        r_wr_data <= {byte_in, r_lo_byte};
                        r_index   <= r_index + 1'b1;
                        // Completion is flagged on the same edge as the final write strobe.
                        if (w_last_word) begin
                            r_state       <= ST_DONE;
                            r_song_loaded <= 1'b1;
                        end else begin
                            r_state <= ST_DATA_LO;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign note_count  = r_note_count;
    assign song_loaded = r_song_loaded;
    assign load_error  = r_load_error;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_song_data_loader.sv
// Directed bench for song_data_loader: drivers feed byte streams, a negedge monitor
// compares every write strobe against an expected queue of {song_loaded, addr, data}.
module tb_song_data_loader;
    import song_data_loader_pkg::*;

    localparam int DEPTH  = 4096;
    localparam int ADDR_W = 12;
    localparam int EW     = 1 + ADDR_W + 16;

    logic              clk;
    logic              reset;
    logic              start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic [15:0]       note_count;
    logic              song_loaded;
    logic              load_error;
    loader_state_t     dbg_state;

    int checks = 0;
    int errors = 0;
    int rand_gaps = 0;

    logic [EW-1:0] exp_q[$];

    song_data_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .note_count (note_count),
        .song_loaded(song_loaded),
        .load_error (load_error),
        .o_dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (wr_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h loaded=%0b, expected no write",
                         wr_addr, wr_data, song_loaded);
            end else begin
                logic [EW-1:0] exp_e;
                exp_e = exp_q.pop_front();
                if ({song_loaded, wr_addr, wr_data} !== exp_e) begin
                    errors++;
                    $display("FAIL write: got loaded=%0b addr=%0h data=%0h, expected loaded=%0b addr=%0h data=%0h",
                             song_loaded, wr_addr, wr_data, exp_e[EW-1], exp_e[EW-2:16], exp_e[15:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    task automatic expect_write(input logic last, input logic [ADDR_W-1:0] addr, input logic [15:0] data);
        exp_q.push_back({last, addr, data});
    endtask

    // drivers: all called and returning at a negedge
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        int gap;
        gap = rand_gaps ? int'($urandom_range(0, 3)) : 0;
        repeat (gap) @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        n = 0;
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) begin
            checks++;
            errors++;
            $display("FAIL byte_ready_timeout: got byte_ready=0 after %0d cycles, expected 1", n);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        byte_in    = 8'h00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"},       32'(dbg_state),   32'(ST_IDLE));
        check({tag, "_byte_ready"},  32'(byte_ready),  32'd0);
        check({tag, "_wr_en"},       32'(wr_en),       32'd0);
        check({tag, "_wr_addr"},     32'(wr_addr),     32'd0);
        check({tag, "_wr_data"},     32'(wr_data),     32'd0);
        check({tag, "_note_count"},  32'(note_count),  32'd0);
        check({tag, "_song_loaded"}, 32'(song_loaded), 32'd0);
        check({tag, "_load_error"},  32'(load_error),  32'd0);
    endtask

    task automatic load_two_words(input string tag, input logic poke_start);
        pulse_start();
        check({tag, "_hdr_lo_state"}, 32'(dbg_state), 32'(ST_HDR_LO));
        check({tag, "_loaded_clear"}, 32'(song_loaded), 32'd0);
        expect_write(1'b0, 12'h000, 16'h1234);
        expect_write(1'b1, 12'h001, 16'h5678);
        send_byte(8'h02);
        send_byte(8'h00);
        if (poke_start) begin
            pulse_start();
            check({tag, "_start_ignored"}, 32'(dbg_state), 32'(ST_DATA_LO));
        end
        send_byte(8'h34);
        send_byte(8'h12);
        send_byte(8'h78);
        send_byte(8'h56);
        @(negedge clk);
        check({tag, "_state_done"},  32'(dbg_state),   32'(ST_DONE));
        check({tag, "_song_loaded"}, 32'(song_loaded), 32'd1);
        check({tag, "_note_count"},  32'(note_count),  32'd2);
        check({tag, "_byte_ready"},  32'(byte_ready),  32'd0);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        @(negedge clk);
        do_reset();
        check_reset_values("reset");

        // basic two-word load
        load_two_words("basic", 1'b0);

        // start in DONE drops song_loaded; empty song finishes with no writes
        pulse_start();
        check("restart_loaded_drop", 32'(song_loaded), 32'd0);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (2) @(negedge clk);
        check("empty_state",  32'(dbg_state),   32'(ST_DONE));
        check("empty_loaded", 32'(song_loaded), 32'd1);
        check("empty_count",  32'(note_count),  32'd0);

        // header 4097 > DEPTH
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h10);
        repeat (3) @(negedge clk);
        check("err_state",      32'(dbg_state),  32'(ST_ERR));
        check("err_load_error", 32'(load_error), 32'd1);
        check("err_byte_ready", 32'(byte_ready), 32'd0);
        check("err_note_count", 32'(note_count), 32'h1001);
        check("err_loaded",     32'(song_loaded), 32'd0);
        pulse_start();
        check("err_cleared",    32'(load_error), 32'd0);
        check("err_restart",    32'(dbg_state),  32'(ST_HDR_LO));
        do_reset();

        // header exactly DEPTH is accepted
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h10);
        check("depth_ok_state", 32'(dbg_state),  32'(ST_DATA_LO));
        check("depth_ok_err",   32'(load_error), 32'd0);
        do_reset();

        // same load with random byte_valid gaps and a start poke mid-load
        rand_gaps = 1;
        load_two_words("gaps", 1'b1);
        rand_gaps = 0;

        // reset right after the first word of a three-word load
        pulse_start();
        expect_write(1'b0, 12'h000, 16'h2211);
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("midreset");
        reset = 1'b0;
        @(negedge clk);
        check("midreset_queue", 32'(exp_q.size()), 32'd0);

        // full three-word load after the interrupted one
        pulse_start();
        expect_write(1'b0, 12'h000, 16'h2211);
        expect_write(1'b0, 12'h001, 16'h4433);
        expect_write(1'b1, 12'h002, 16'h6655);
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        @(negedge clk);
        check("three_state",  32'(dbg_state),   32'(ST_DONE));
        check("three_loaded", 32'(song_loaded), 32'd1);
        check("three_count",  32'(note_count),  32'd3);
        check("three_queue",  32'(exp_q.size()), 32'd0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
